// File: rtl/mini_ex_core_pkg.sv
// Shared widths, request payloads and flop macros for the mini_ex core register file.
// The payload structs describe one read/write port at the default core configuration.

`ifndef MINI_EX_CORE_DFF_MACROS
`define MINI_EX_CORE_DFF_MACROS
`define MAFIA_DFF(q, d, clk) always_ff @(posedge clk) q <= (d);
`define MAFIA_DFF_RST(q, d, clk, rst) always_ff @(posedge clk) if (rst) q <= '0; else q <= (d);
`define MAFIA_DFF_RST_EN(q, d, en, clk, rst) always_ff @(posedge clk) if (rst) q <= '0; else if (en) q <= (d);
`endif

package mini_ex_core_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ADDR_W     = $clog2(NUM_REGS);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
    } rf_rd_req_t;

    typedef struct packed {
        logic                  en;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_WIDTH-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/mini_ex_core_rf_byp.sv
// Per-read-port write-first bypass: the highest-numbered matching write port wins,
// and register 0 reads as zero / not pending when it is hardwired.

module mini_ex_core_rf_byp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0]        arr_data,
    input  logic                         arr_pend,
    output logic [DATA_WIDTH-1:0]        sel_data_c,
    output logic                         sel_pend_c
);

    always_comb begin
        sel_data_c = arr_data;
        sel_pend_c = arr_pend;
        // Later ports overwrite earlier ones, so port 1 takes priority.
        for (int w = 0; w < int'(NUM_WR); w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr)) begin
                sel_data_c = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            sel_data_c = '0;
            sel_pend_c = 1'b0;
        end
    end

endmodule

// File: rtl/mini_ex_core_rf_mp.sv
// Multi-ported register file with a pending-result scoreboard, one-cycle registered
// reads, write-first bypass and optional hardwired-zero register 0.

module mini_ex_core_rf_mp #(
    parameter int unsigned DATA_WIDTH = mini_ex_core_pkg::DATA_WIDTH,
    parameter int unsigned NUM_REGS   = mini_ex_core_pkg::NUM_REGS,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned ZERO_REG   = 1,
    localparam int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                         Clock,
    input  logic                         Rst,
    input  logic [NUM_RD*ADDR_W-1:0]     RdAddrQ100H,
    input  logic [NUM_RD-1:0]            RdEnQ100H,
    input  logic [NUM_WR-1:0]            WrEnQ100H,
    input  logic [NUM_WR*ADDR_W-1:0]     WrAddrQ100H,
    input  logic [NUM_WR*DATA_WIDTH-1:0] WrDataQ100H,
    input  logic                         PendSetEnQ100H,
    input  logic [ADDR_W-1:0]            PendSetAddrQ100H,
    output logic [NUM_RD*DATA_WIDTH-1:0] RdDataQ101H,
    output logic [NUM_RD-1:0]            RdPendQ101H,
    output logic [NUM_REGS-1:0]          PendVecQ100H
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pend_q;
    logic [NUM_REGS-1:0]   pend_next;

    // Storage array; later write ports win on an address collision.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < int'(NUM_WR); w++) begin
                if (WrEnQ100H[w] &&
                    !((ZERO_REG != 0) && (WrAddrQ100H[w*ADDR_W +: ADDR_W] == '0))) begin
                    regs[WrAddrQ100H[w*ADDR_W +: ADDR_W]] <= WrDataQ100H[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Writes retire a producer, PendSet issues a new one; the new producer wins.
    always_comb begin
        pend_next = pend_q;
        for (int w = 0; w < int'(NUM_WR); w++) begin
            if (WrEnQ100H[w]) begin
                pend_next[WrAddrQ100H[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (PendSetEnQ100H) begin
            pend_next[PendSetAddrQ100H] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_next[0] = 1'b0;
        end
    end

    `MAFIA_DFF_RST(pend_q, pend_next, Clock, Rst)

    assign PendVecQ100H = pend_q;

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        logic [ADDR_W-1:0]     rd_addr;
        logic [DATA_WIDTH-1:0] byp_data;
        logic                  byp_pend;
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_pend_q;

        assign rd_addr = RdAddrQ100H[p*ADDR_W +: ADDR_W];

        mini_ex_core_rf_byp #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_W     (ADDR_W),
            .NUM_WR     (NUM_WR),
            .ZERO_REG   (ZERO_REG)
        ) u_byp (
            .rd_addr    (rd_addr),
            .wr_en      (WrEnQ100H),
            .wr_addr    (WrAddrQ100H),
            .wr_data    (WrDataQ100H),
            .arr_data   (regs[rd_addr]),
            .arr_pend   (pend_next[rd_addr]),
            .sel_data_c (byp_data),
            .sel_pend_c (byp_pend)
        );

        // A disabled port holds its last result.
        `MAFIA_DFF_RST_EN(rd_data_q, byp_data, RdEnQ100H[p], Clock, Rst)
        `MAFIA_DFF_RST_EN(rd_pend_q, byp_pend, RdEnQ100H[p], Clock, Rst)

        assign RdDataQ101H[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
        assign RdPendQ101H[p]                          = rd_pend_q;
    end

endmodule

// File: tb/tb_mini_ex_core_rf_mp.sv
// Directed bench for mini_ex_core_rf_mp at the default configuration
// (32 x 32-bit, 2 read ports, 2 write ports, register 0 hardwired).

module tb_mini_ex_core_rf_mp;
    import mini_ex_core_pkg::*;

    logic                    clk;
    logic                    rst;
    logic [2*ADDR_W-1:0]     rd_addr;
    logic [1:0]              rd_en;
    logic [1:0]              wr_en;
    logic [2*ADDR_W-1:0]     wr_addr;
    logic [2*DATA_WIDTH-1:0] wr_data;
    logic                    pset_en;
    logic [ADDR_W-1:0]       pset_addr;
    logic [2*DATA_WIDTH-1:0] rd_data;
    logic [1:0]              rd_pend;
    logic [NUM_REGS-1:0]     pend_vec;

    int n_checks = 0;
    int n_errors = 0;

    mini_ex_core_rf_mp #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .NUM_RD     (2),
        .NUM_WR     (2),
        .ZERO_REG   (1)
    ) u_dut (
        .Clock            (clk),
        .Rst              (rst),
        .RdAddrQ100H      (rd_addr),
        .RdEnQ100H        (rd_en),
        .WrEnQ100H        (wr_en),
        .WrAddrQ100H      (wr_addr),
        .WrDataQ100H      (wr_data),
        .PendSetEnQ100H   (pset_en),
        .PendSetAddrQ100H (pset_addr),
        .RdDataQ101H      (rd_data),
        .RdPendQ101H      (rd_pend),
        .PendVecQ100H     (pend_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en   = '0;
        wr_en   = '0;
        pset_en = 1'b0;
    endtask

    task automatic rd(input int p, input logic [ADDR_W-1:0] a);
        rf_rd_req_t r;
        r.en = 1'b1;
        r.addr = a;
        rd_en[p] = r.en;
        rd_addr[p*ADDR_W +: ADDR_W] = r.addr;
    endtask

    task automatic wr(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_WIDTH-1:0] d);
        rf_wr_req_t r;
        r.en = 1'b1;
        r.addr = a;
        r.data = d;
        wr_en[p] = r.en;
        wr_addr[p*ADDR_W +: ADDR_W] = r.addr;
        wr_data[p*DATA_WIDTH +: DATA_WIDTH] = r.data;
    endtask

    task automatic pset(input logic [ADDR_W-1:0] a);
        pset_en   = 1'b1;
        pset_addr = a;
    endtask

    function automatic logic [31:0] data_of(input int p);
        logic [2*DATA_WIDTH-1:0] v;
        v = rd_data;
        return v[p*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        pset_addr = '0;
        idle();
        tick();
        // Traffic during reset must be dropped.
        wr(0, 5'd4, 32'hAAAA_5555);
        pset(5'd4);
        rd(0, 5'd4);
        tick();
        idle();
        check_eq("rst_data0", 64'(data_of(0)), 64'h0);
        check_eq("rst_data1", 64'(data_of(1)), 64'h0);
        check_eq("rst_pend", 64'(rd_pend), 64'h0);
        check_eq("rst_pendvec", 64'(pend_vec), 64'h0);

        rst = 1'b0;
        rd(0, 5'd4);
        tick();
        idle();
        check_eq("post_rst_read", 64'(data_of(0)), 64'h0);

        wr(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        rd(0, 5'd5);
        tick();
        idle();
        check_eq("r5_read", 64'(data_of(0)), 64'hDEAD_BEEF);

        wr(1, 5'd6, 32'h0000_1234);
        rd(0, 5'd6);
        tick();
        idle();
        check_eq("bypass_data", 64'(data_of(0)), 64'h1234);
        check_eq("bypass_pend", 64'(rd_pend[0]), 64'h0);

        rd_addr[0 +: ADDR_W] = 5'd5;
        tick();
        check_eq("hold_data", 64'(data_of(0)), 64'h1234);

        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        rd(0, 5'd7);
        rd(1, 5'd7);
        tick();
        idle();
        check_eq("dual_wr_p0", 64'(data_of(0)), 64'h22);
        check_eq("dual_wr_p1", 64'(data_of(1)), 64'h22);
        rd(1, 5'd7);
        tick();
        idle();
        check_eq("dual_wr_later", 64'(data_of(1)), 64'h22);

        wr(0, 5'd0, 32'hFFFF_FFFF);
        pset(5'd0);
        rd(0, 5'd0);
        rd(1, 5'd0);
        tick();
        idle();
        check_eq("r0_byp_data0", 64'(data_of(0)), 64'h0);
        check_eq("r0_byp_data1", 64'(data_of(1)), 64'h0);
        check_eq("r0_byp_pend", 64'(rd_pend), 64'h0);
        rd(0, 5'd0);
        tick();
        idle();
        check_eq("r0_data", 64'(data_of(0)), 64'h0);
        check_eq("r0_pendvec", 64'(pend_vec), 64'h0);

        pset(5'd3);
        tick();
        idle();
        rd(1, 5'd3);
        tick();
        idle();
        check_eq("r3_pend", 64'(rd_pend[1]), 64'h1);
        check_eq("r3_pendvec", 64'(pend_vec), 64'h8);
        wr(0, 5'd3, 32'h55);
        rd(1, 5'd3);
        tick();
        idle();
        check_eq("r3_wr_data", 64'(data_of(1)), 64'h55);
        check_eq("r3_wr_pend", 64'(rd_pend[1]), 64'h0);
        check_eq("r3_wr_pendvec", 64'(pend_vec), 64'h0);

        pset(5'd3);
        rd(0, 5'd3);
        tick();
        idle();
        check_eq("r3_set_rd_pend", 64'(rd_pend[0]), 64'h1);

        pset(5'd9);
        wr(1, 5'd9, 32'h1);
        tick();
        idle();
        check_eq("r9_pendvec", 64'(pend_vec), 64'h208);
        rd(0, 5'd9);
        tick();
        idle();
        check_eq("r9_data", 64'(data_of(0)), 64'h1);
        check_eq("r9_pend", 64'(rd_pend[0]), 64'h1);

        // Reset while a read is issued drops the result.
        rst = 1'b1;
        rd(0, 5'd9);
        tick();
        idle();
        rst = 1'b0;
        check_eq("midrst_data", 64'(data_of(0)), 64'h0);
        check_eq("midrst_pend", 64'(rd_pend[0]), 64'h0);
        check_eq("midrst_pendvec", 64'(pend_vec), 64'h0);

        for (int i = 1; i < 32; i += 2) begin
            wr(0, ADDR_W'(i), 32'(i));
            if (i + 1 < 32) wr(1, ADDR_W'(i + 1), 32'(i + 1));
            pset(ADDR_W'(i));
            tick();
            idle();
        end
        check_eq("fill_pendvec", 64'(pend_vec), 64'hAAAA_AAAA);
        rd(1, 5'd31);
        rd(0, 5'd2);
        tick();
        idle();
        check_eq("fill_r31", 64'(data_of(1)), 64'd31);
        check_eq("fill_r31_pend", 64'(rd_pend[1]), 64'h1);
        check_eq("fill_r2", 64'(data_of(0)), 64'd2);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("clr_pendvec", 64'(pend_vec), 64'h0);
        for (int i = 1; i < 32; i++) begin
            rd(0, ADDR_W'(i));
            tick();
            idle();
            check_eq($sformatf("clr_r%0d", i), 64'(data_of(0)), 64'h0);
        end
        check_eq("clr_pend", 64'(rd_pend[0]), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
